mac_feeder: RTL and testbench

MAC_FEEDER -- requirements
Module: mac_feeder

---
 rtl/mac_pkg.sv | 7 +
 rtl/mac_operand_buf.sv | 20 ++
 rtl/mac_feeder.sv | 88 ++++++++
 tb/tb_mac_feeder.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// mac_pkg: shared FSM state type and default geometry for the MAC operand feeder.
package mac_pkg;
  typedef enum logic [1:0] {ST_LOAD, ST_STREAM, ST_DRAIN, ST_RESULT} state_t;
  localparam int WIDTH_DEF = 16;
  localparam int DEPTH_DEF = 8;
  localparam int DRAIN_DEF = 1;
endpackage

// File: rtl/mac_operand_buf.sv
// mac_operand_buf: DEPTH x {in, w} register file, one write port, one combinational read port.
module mac_operand_buf #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [AW-1:0]           waddr,
  input  logic signed [WIDTH-1:0] win,
  input  logic signed [WIDTH-1:0] ww,
  input  logic [AW-1:0]           raddr,
  output logic signed [WIDTH-1:0] rin,
  output logic signed [WIDTH-1:0] rw
);
  logic [2*WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= {win, ww};
  assign {rin, rw} = mem[raddr];
endmodule

// File: rtl/mac_feeder.sv
// mac_feeder: buffers a vector of operand pairs, streams it gap-free into an external MAC,
// waits for the accumulator to settle and holds the dot product until the consumer takes it.
module mac_feeder
  import mac_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int DRAIN = DRAIN_DEF
) (
  input  logic                    clk,
  input  logic                    rstb,
  input  logic                    ld_valid,
  output logic                    ld_ready,
  input  logic signed [WIDTH-1:0] ld_in,
  input  logic signed [WIDTH-1:0] ld_w,
  output logic signed [WIDTH-1:0] mac_in,
  output logic signed [WIDTH-1:0] mac_w,
  output logic                    mac_en,
  output logic                    mac_clr,
  input  logic signed [WIDTH-1:0] mac_out,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic signed [WIDTH-1:0] res_data
);
  localparam int AW = $clog2(DEPTH);
  localparam int DW = $clog2(DRAIN + 1);
  state_t state_q, state_d;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [DW-1:0] dc_q, dc_d;
  logic signed [WIDTH-1:0] res_q, res_d, b_in, b_w;
  logic ld_hs, st;
  mac_operand_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_buf (
    .clk(clk), .we(ld_hs), .waddr(wr_q), .win(ld_in), .ww(ld_w),
    .raddr(rd_q), .rin(b_in), .rw(b_w)
  );
  // ld_ready also drops while reset is held so every output reads 0 during reset
  assign ld_ready  = state_q == ST_LOAD && !rstb;
  assign ld_hs     = ld_valid && ld_ready;
  assign st        = state_q == ST_STREAM;
  assign mac_in    = st ? b_in : '0;
  assign mac_w     = st ? b_w : '0;
  assign mac_en    = st;
  assign mac_clr   = st && rd_q == '0;
  assign res_valid = state_q == ST_RESULT;
  assign res_data  = res_q;
  always_comb begin
    state_d = state_q;
    wr_d = wr_q;
    rd_d = rd_q;
    dc_d = dc_q;
    res_d = res_q;
    if (state_q == ST_LOAD && ld_hs) begin
      wr_d = wr_q + AW'(1);
      if (wr_q == AW'(DEPTH - 1)) begin
        state_d = ST_STREAM;
        rd_d = '0;
      end
    end
    if (st) begin
      rd_d = rd_q + AW'(1);
      state_d = rd_q == AW'(DEPTH - 1) ? ST_DRAIN : ST_STREAM;
      dc_d = '0;
    end
    if (state_q == ST_DRAIN) begin
      dc_d = dc_q + DW'(1);
      if (dc_q == DW'(DRAIN - 1)) begin
        dc_d = '0;
        res_d = mac_out;
        state_d = ST_RESULT;
      end
    end
    if (state_q == ST_RESULT && res_ready) state_d = ST_LOAD;
  end
  always_ff @(posedge clk or posedge rstb)
    if (rstb) begin
      state_q <= ST_LOAD;
      wr_q <= '0;
      rd_q <= '0;
      dc_q <= '0;
      res_q <= '0;
    end else begin
      state_q <= state_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      dc_q <= dc_d;
      res_q <= res_d;
    end
endmodule

// File: tb/tb_mac_feeder.sv
// tb_mac_feeder: directed and randomized vectors against a dot-product reference and a 1-cycle MAC model.
module tb_mac_feeder;
  localparam int W = 16;
  localparam int D = 8;
  logic clk = 0, rstb = 0, ld_valid = 0, res_ready = 0;
  logic signed [W-1:0] ld_in = 0, ld_w = 0;
  logic ld_ready, mac_en, mac_clr, res_valid;
  logic signed [W-1:0] mac_in, mac_w, mac_out, res_data;
  int checks = 0, errors = 0;

  mac_feeder #(.WIDTH(W), .DEPTH(D), .DRAIN(1)) dut (
    .clk(clk), .rstb(rstb), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_in(ld_in), .ld_w(ld_w), .mac_in(mac_in), .mac_w(mac_w),
    .mac_en(mac_en), .mac_clr(mac_clr), .mac_out(mac_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
  );

  always #5 clk = ~clk;

  logic signed [W-1:0] acc;
  logic signed [31:0] prod;
  assign prod = 32'(mac_in) * 32'(mac_w);
  assign mac_out = acc;
  always @(posedge clk or posedge rstb)
    if (rstb) acc <= '0;
    else if (mac_en) acc <= mac_clr ? prod[W-1:0] : acc + prod[W-1:0];

  typedef struct {logic signed [W-1:0] i; logic signed [W-1:0] w; logic c;} ev_t;
  ev_t q[$];
  always @(negedge clk)
    if (mac_en) q.push_back('{mac_in, mac_w, mac_clr});

  logic signed [W-1:0] vin[D], vw[D];

  function automatic logic signed [W-1:0] ref_dot();
    int s = 0;
    for (int i = 0; i < D; i++) s += int'(vin[i]) * int'(vw[i]);
    return s[W-1:0];
  endfunction

  task automatic set_std();
    int a[D] = '{1, 4, 7, -2, 3, -5, 2, 3};
    int b[D] = '{4, -3, 2, -1, 2, 1, -5, 7};
    for (int i = 0; i < D; i++) begin vin[i] = W'(a[i]); vw[i] = W'(b[i]); end
  endtask

  task automatic set_const(input int a, input int b);
    for (int i = 0; i < D; i++) begin vin[i] = W'(a); vw[i] = W'(b); end
  endtask

  // gap: 0 none, 1 alternate cycles, 2 random
  task automatic load_vec(input int gap);
    q.delete();
    for (int i = 0; i < D; i++) begin
      int n = 0;
      ld_valid = 1; ld_in = vin[i]; ld_w = vw[i];
      while (!ld_ready && n < 50) begin @(negedge clk); n++; end
      if (n == 50) begin
        checks++; errors++;
        $display("FAIL load_timeout pair=%0d ld_ready=%0b required 1", i, ld_ready);
      end
      @(negedge clk);
      ld_valid = 0;
      if (i == D - 1) begin
        checks++;
        if (ld_ready !== 1'b0) begin errors++; $display("FAIL ld_ready_after_last got=%0b exp=0", ld_ready); end
      end else if (gap == 1 || (gap == 2 && $urandom_range(1, 0) == 1)) @(negedge clk);
    end
  endtask

  task automatic finish_vec(input string name, input int hold, input bit junk);
    int n = 0;
    logic signed [W-1:0] exp;
    ev_t e;
    exp = ref_dot();
    while (!res_valid && n < 100) begin
      if (junk) begin ld_valid = 1'($urandom_range(1, 0)); ld_in = W'($urandom); ld_w = W'($urandom); end
      @(negedge clk); n++;
    end
    ld_valid = 0;
    checks++;
    if (res_valid !== 1'b1) begin errors++; $display("FAIL %s res_timeout got=%0b exp=1", name, res_valid); end
    checks++;
    if (q.size() != D) begin errors++; $display("FAIL %s mac_en_cycles got=%0d exp=%0d", name, q.size(), D); end
    for (int i = 0; i < D && q.size() > 0; i++) begin
      e = q.pop_front();
      checks++;
      if (e.i !== vin[i] || e.w !== vw[i] || e.c !== (i == 0)) begin
        errors++;
        $display("FAIL %s pair%0d got=(%0d,%0d,clr%0b) exp=(%0d,%0d,clr%0b)", name, i, e.i, e.w, e.c, vin[i], vw[i], i == 0);
      end
    end
    for (int h = 0; h < hold; h++) begin
      checks++;
      if (res_valid !== 1'b1 || res_data !== exp || ld_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s hold%0d got=(v%0b,%0d,rdy%0b) exp=(v1,%0d,rdy0)", name, h, res_valid, res_data, ld_ready, exp);
      end
      ld_valid = 1'(h % 2); ld_in = W'($urandom); ld_w = W'($urandom);
      @(negedge clk);
    end
    ld_valid = 0;
    res_ready = 1;
    checks++;
    if (res_valid !== 1'b1 || res_data !== exp) begin
      errors++;
      $display("FAIL %s res_data got=(v%0b,%0d) exp=(v1,%0d)", name, res_valid, res_data, exp);
    end
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b0 || ld_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s after_accept got=(v%0b,rdy%0b) exp=(v0,rdy1)", name, res_valid, ld_ready);
    end
  endtask

  task automatic test_reset();
    #1 rstb = 1;
    repeat (2) @(negedge clk);
    checks++;
    if ({mac_en, mac_clr, res_valid, ld_ready} !== 4'b0 || mac_in !== 0 || mac_w !== 0 || res_data !== 0) begin
      errors++;
      $display("FAIL reset_outputs got=en%0b clr%0b v%0b rdy%0b in%0d w%0d res%0d exp=all 0",
               mac_en, mac_clr, res_valid, ld_ready, mac_in, mac_w, res_data);
    end
    rstb = 0;
    @(negedge clk);
    checks++;
    if (ld_ready !== 1'b1 || res_valid !== 1'b0) begin
      errors++; $display("FAIL reset_release got=(rdy%0b,v%0b) exp=(rdy1,v0)", ld_ready, res_valid);
    end
  endtask

  task automatic test_basic();
    set_std(); res_ready = 0;
    load_vec(0); finish_vec("basic", 0, 0); res_ready = 0;
  endtask

  task automatic test_alternate();
    set_std();
    load_vec(1); finish_vec("alternate", 0, 0); res_ready = 0;
  endtask

  task automatic test_hold();
    set_std();
    load_vec(0); finish_vec("hold", 5, 0); res_ready = 0;
  endtask

  task automatic test_reset_mid();
    bit seen = 0;
    set_std();
    load_vec(0);
    repeat (3) @(negedge clk);
    checks++;
    if (mac_en !== 1'b1 || mac_in !== vin[3]) begin
      errors++; $display("FAIL midrst_pre got=(en%0b,%0d) exp=(en1,%0d)", mac_en, mac_in, vin[3]);
    end
    #2 rstb = 1;
    #1;
    checks++;
    if (mac_en !== 1'b0 || mac_in !== 0 || mac_w !== 0 || res_valid !== 1'b0 || res_data !== 0) begin
      errors++;
      $display("FAIL midrst_async got=(en%0b,in%0d,w%0d,v%0b,res%0d) exp=all 0", mac_en, mac_in, mac_w, res_valid, res_data);
    end
    @(negedge clk);
    rstb = 0;
    repeat (20) begin @(negedge clk); if (res_valid) seen = 1; end
    checks++;
    if (seen) begin errors++; $display("FAIL midrst_no_result got=res_valid seen exp=none"); end
    set_const(1, 1);
    load_vec(0); finish_vec("after_reset", 0, 0); res_ready = 0;
  endtask

  task automatic test_back_to_back();
    res_ready = 1;
    set_std();
    load_vec(0); finish_vec("b2b_first", 0, 0);
    set_const(-2, 3);
    load_vec(0); finish_vec("b2b_second", 0, 0);
    res_ready = 0;
  endtask

  task automatic test_random();
    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < D; i++) begin vin[i] = W'($urandom); vw[i] = W'($urandom); end
      res_ready = 1'($urandom_range(1, 0));
      load_vec(2);
      finish_vec("random", res_ready ? 0 : int'($urandom_range(3, 0)), 1);
      res_ready = 0;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_alternate();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
